fifo_burst_reader: RTL
======================

Name: fifo_burst_reader

Overview:
- Downstream consumer of the FIFO read-address counter/FSM, which produces a read strobe and an incrementing address once per cycle with no stall input.
- Owns a small register-file memory with a write port for filling and a read port driven by that counter.
- Fetches each addressed word and buffers it in an output queue.
- Presents the words on a valid/ready stream, tags the final word of each burst, and flags drops caused by back-pressure.

Parameters:
- DATA_W, 8, data word width.
- DEPTH, 4, memory words. Must equal the counter's COUNTER_LEN.
- ADDR_W, 2**$clog2(DEPTH) bits wide address, i.e. the counter's output width (derived, not overridable).
- OUT_DEPTH, 4, output queue entries. Must be at least 2.

Ports:
- clk  in  1  sole clock. Everything is on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  memory write strobe.
- wr_addr  in  $clog2(DEPTH)  write address.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read strobe from the counter (its "read").
- rd_addr  in  ADDR_W  read address from the counter (its "counter_out").
- out_data  out  DATA_W  queue head word.
- out_valid  out  1  queue head valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  head word is the last word of its burst.
- burst_done  out  1  one-cycle pulse when a last-tagged word is accepted.
- busy  out  1  burst in progress or queue not empty.
- overflow  out  1  sticky: a word was dropped.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - The only reset is the synchronous active-high rst, sampled on the rising edge of clk.
  - Reset values: out_valid=0, out_data=0, out_last=0, burst_done=0, busy=0, overflow=0. Queue is emptied and the FSM goes to IDLE.
  - Memory contents are not reset.
- Memory write:
  - When wr_en, mem[wr_addr] <= wr_data.
  - A read of the same address in the same cycle returns the old data.
- Read stage (stage S1):
  - On cycle N with rd_en=1: s1_data <= mem[rd_addr], s1_valid <= 1.
  - An address >= DEPTH returns 0.
  - With rd_en=0: s1_valid <= 0.
  - Last-word tag, computed in cycle N+1: s1_last = s1_valid & ~rd_en. A word is last when the strobe has dropped in the cycle after it was fetched.
- Output queue:
  - Circular buffer, OUT_DEPTH entries, each entry {data, last}.
  - Push at the end of N+1 when s1_valid. The word appears on the output at N+2, so rd_en-to-out_valid latency is 2 cycles.
  - Pop when out_valid & out_ready.
  - out_data shows the head word while out_valid=1 and is 0 when the queue is empty.
  - Full, push and pop in the same cycle: both are performed and the count is unchanged.
  - Full, push without pop: the word is dropped and overflow is set to 1 until rst. If the dropped word carried last, the last tag is lost too.
  - Empty, push and pop in the same cycle: no pop happens (out_valid is 0), the push is performed.
- FSM:
  - States: IDLE, BURST, DRAIN.
  - IDLE -> BURST when rd_en=1.
  - BURST -> DRAIN when an S1 word tagged last is pushed.
  - DRAIN -> IDLE when the queue holds no further entries after the current pop.
  - DRAIN -> BURST on a new rd_en (back-to-back bursts are allowed; last tags stay per word).
- Status outputs:
  - burst_done is a registered pulse, high in the cycle after a last-tagged word is popped.
  - busy = (state != IDLE) | queue not empty, registered.
- rst mid-burst: S1 and the queue are discarded and no burst_done is produced. A later rd_en starts a fresh burst.

Optional Feature:
- Macro FIFO_BURST_READER_PARITY_EN.
- Defined:
  - Adds an output port out_parity (1 bit) = ^out_data, carried as an extra bit in each queue entry and computed at push time.
  - out_parity is 0 when the queue is empty and after reset.
- Undefined: the port and the storage bit do not exist and all other behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - the queue-entry struct typedef {data, last[, parity]};
  - an enum typedef for the FSM states (IDLE, BURST, DRAIN);
  - a function addr_w(depth) returning 2**$clog2(depth).
- One sub-module is natural: fifo_out_queue, the parameterised circular buffer with push/pop, full/empty and the drop-on-full overflow flag.
- Memory, S1 and the FSM stay in the top level.

Test Plan:
- Fill mem with 0x11,0x22,0x33,0x44. rd_en high for 4 cycles with addr 0..3, out_ready=1 -> out_data 0x11..0x44 starting 2 cycles after the first rd_en. out_last=1 only on 0x44. burst_done pulses once. busy falls afterwards.
- Same burst with out_ready=0 throughout, OUT_DEPTH=4 -> 4 words held, overflow stays 0. Raising out_ready drains 0x11..0x44 in order.
- OUT_DEPTH=2, out_ready=0, 4-word burst -> overflow=1 and stays 1. After ready, only 0x11 and 0x22 appear, with no last and no burst_done.
- Write 0x55 to address 1 in the same cycle rd_en reads address 1 (old value 0x22) -> 0x22 is output. A following read of address 1 returns 0x55.
- Assert rst during the 3rd cycle of a burst -> every output equals its reset value in the next cycle, no burst_done. A fresh 4-word burst then produces all 4 words correctly.
- With FIFO_BURST_READER_PARITY_EN defined, output 0x07 -> out_parity=1; output 0x03 -> out_parity=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO burst reader: queue entry, FSM states, counter address width.
// Queue entries carry a parity bit only when FIFO_BURST_READER_PARITY_EN is defined.
package fifo_pkg;

  // Queue entry data width; the top-level DATA_W must match it.
  localparam int FIFO_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [FIFO_DATA_W-1:0] data;
    logic                   last;
`ifdef FIFO_BURST_READER_PARITY_EN
    logic                   parity;
`endif
  } q_entry_t;

  function automatic int addr_w(input int depth);
    return 2 ** $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_out_queue.sv
// Circular output queue. Head appears the cycle after a push. A push into a full queue
// with no pop in the same cycle is dropped and sets the sticky overflow flag.
module fifo_out_queue
  import fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  q_entry_t push_entry,
  input  logic     pop,
  output q_entry_t head,
  output logic     valid,
  output logic     empty_next,
  output logic     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  q_entry_t         store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (count != '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & valid;
  // A simultaneous pop frees the slot, so a full queue still accepts the push.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_nxt = count;
    if (do_push & ~do_pop) begin
      count_nxt = count + 1'b1;
    end else if (do_pop & ~do_push) begin
      count_nxt = count - 1'b1;
    end
  end

  assign empty_next = (count_nxt == '0);
  assign head       = valid ? store[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_nxt;
      if (push & ~do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Fetches counter-addressed words into an output queue: rd_en to out_valid is 2 cycles; words
// arriving at a full, stalled queue are dropped (sticky overflow). Option: FIFO_BURST_READER_PARITY_EN.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter  int DATA_W    = FIFO_DATA_W,
  parameter  int DEPTH     = 4,
  parameter  int OUT_DEPTH = 4,
  localparam int ADDR_W    = addr_w(DEPTH),
  localparam int WA_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WA_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              burst_done,
  output logic              busy,
`ifdef FIFO_BURST_READER_PARITY_EN
  output logic              out_parity,
`endif
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] s1_data;
  logic              s1_valid;
  logic              s1_last;
  q_entry_t          push_entry;
  q_entry_t          q_head;
  logic              q_valid;
  logic              q_empty_next;
  state_t            state;
  state_t            state_nxt;
  logic              busy_d;
  logic              burst_done_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The counter's address is wider than the memory; out-of-range addresses read as zero.
  always_comb begin
    rd_word = '0;
    if (rd_addr < DEPTH_A) begin
      rd_word = mem[rd_addr[WA_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) s1_data <= rd_word;
    end
  end

  // The strobe dropping right after a fetch marks that fetched word as the burst's last.
  assign s1_last = s1_valid & ~rd_en;

  always_comb begin
    push_entry      = '0;
    push_entry.data = s1_data;
    push_entry.last = s1_last;
`ifdef FIFO_BURST_READER_PARITY_EN
    push_entry.parity = ^s1_data;
`endif
  end

  fifo_out_queue #(
    .DEPTH (OUT_DEPTH)
  ) u_out_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (s1_valid),
    .push_entry (push_entry),
    .pop        (out_ready),
    .head       (q_head),
    .valid      (q_valid),
    .empty_next (q_empty_next),
    .overflow   (overflow)
  );

  assign out_valid = q_valid;
  assign out_data  = q_head.data;
  assign out_last  = q_head.last;
`ifdef FIFO_BURST_READER_PARITY_EN
  assign out_parity = q_head.parity;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_en) state_nxt = BURST;
      BURST:   if (s1_last) state_nxt = DRAIN;
      DRAIN: begin
        if (rd_en) begin
          state_nxt = BURST;
        end else if (q_empty_next) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_d       = (state_nxt != IDLE) | ~q_empty_next;
    burst_done_d = q_valid & out_ready & q_head.last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      busy       <= busy_d;
      burst_done <= burst_done_d;
    end
  end

endmodule
